// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Owns the single write port of the 8x32 register file. After reset it
// walks every address writing zero (CLEAR), then arbitrates the port between
// requester A (execute) and requester B (memory) with round-robin priority
// through a registered write stage (RUN).
// Optional feature macro: RF_BYPASS_EN -- when defined, both read ports
// forward the in-flight write-stage data on an address match.
module rf_write_arbiter #(
    parameter int AW   = 3,
    parameter int DW   = 32,
    parameter int NREG = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    output logic          rf_we,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wd,
    output logic          init_done,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    input  logic [DW-1:0] rf_rd1,
    input  logic [DW-1:0] rf_rd2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [AW-1:0] cnt_r;
    logic          last_b_r;   // 1: the most recent grant went to B
    logic          grant_a_s;
    logic          grant_b_s;

    // State register; reset always returns to the zero-fill phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_CLEAR;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and round-robin grant (ties go to the requester not served last).
    always_comb begin
        state_s   = state_r;
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        case (state_r)
            ST_CLEAR: begin
                if (cnt_r == LAST_IDX) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_CLEAR;
                end
            end
            ST_RUN: begin
                state_s = ST_RUN;
                if (a_valid && b_valid) begin
                    if (last_b_r) begin
                        grant_a_s = 1'b1;
                    end else begin
                        grant_b_s = 1'b1;
                    end
                end else if (a_valid) begin
                    grant_a_s = 1'b1;
                end else if (b_valid) begin
                    grant_b_s = 1'b1;
                end else begin
                    grant_a_s = 1'b0;
                    grant_b_s = 1'b0;
                end
            end
            default: begin
                state_s = ST_CLEAR;
            end
        endcase
    end

    // A grant is only ever raised for a valid requester, so ready equals grant.
    assign a_ready = grant_a_s;
    assign b_ready = grant_b_s;

    // Write stage, clear counter, init flag and last-grant memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= {AW{1'b0}};
            last_b_r  <= 1'b1;
            rf_we     <= 1'b0;
            rf_wa     <= {AW{1'b0}};
            rf_wd     <= {DW{1'b0}};
            init_done <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    rf_we <= 1'b1;
                    rf_wa <= cnt_r;
                    rf_wd <= {DW{1'b0}};
                    cnt_r <= cnt_r + AW'(1);
                    if (cnt_r == LAST_IDX) begin
                        init_done <= 1'b1;
                    end else begin
                        init_done <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (grant_a_s) begin
                        rf_we    <= 1'b1;
                        rf_wa    <= a_addr;
                        rf_wd    <= a_data;
                        last_b_r <= 1'b0;
                    end else if (grant_b_s) begin
                        rf_we    <= 1'b1;
                        rf_wa    <= b_addr;
                        rf_wd    <= b_data;
                        last_b_r <= 1'b1;
                    end else begin
                        // Idle: address and data hold, only the enable drops.
                        rf_we <= 1'b0;
                    end
                end
                default: begin
                    rf_we <= 1'b0;
                end
            endcase
        end
    end

`ifdef RF_BYPASS_EN
    // Read-after-write forwarding from the write stage, active in CLEAR as well.
    always_comb begin
        if (rf_we && (rf_wa == ra1)) begin
            rd1 = rf_wd;
        end else begin
            rd1 = rf_rd1;
        end
        if (rf_we && (rf_wa == ra2)) begin
            rd2 = rf_wd;
        end else begin
            rd2 = rf_rd2;
        end
    end
`else
    // Without forwarding the read addresses only go to the register file.
    logic unused_ra_s;
    assign unused_ra_s = ^{ra1, ra2};
    assign rd1 = rf_rd1;
    assign rd2 = rf_rd2;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus a
// randomized phase, all compared against a transaction-level reference model.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [2:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        rf_we;
    logic [2:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        init_done;
    logic [2:0]  ra1, ra2;
    logic [31:0] rf_rd1, rf_rd2;
    logic [31:0] rd1, rd2;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: last winner and the expected write stage.
    bit          m_last_b;
    logic        exp_ar, exp_br;
    logic        cur_we, nxt_we;
    logic [2:0]  cur_wa, nxt_wa;
    logic [31:0] cur_wd, nxt_wd;

    // Stand-in for the register file instance behind the write port.
    logic [31:0] rf_mem [8];

`ifdef RF_BYPASS_EN
    localparam logic [31:0] BYP_EXP = 32'h2222_2222;
`else
    localparam logic [31:0] BYP_EXP = 32'h0000_0000;
`endif

    rf_write_arbiter #(.AW(3), .DW(32), .NREG(8)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .init_done(init_done),
        .ra1(ra1), .ra2(ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .rd1(rd1), .rd2(rd2)
    );

    always #5 clk = ~clk;

    // Register file storage, written from the arbiter's write port.
    always @(posedge clk) begin
        if (rf_we) rf_mem[rf_wa] <= rf_wd;
    end

    // Grant rule: a lone requester wins; on a tie the one not served last wins.
    function automatic void predict();
        exp_ar = a_valid && (!b_valid || m_last_b);
        exp_br = b_valid && !exp_ar;
        if (exp_ar) begin
            nxt_we = 1'b1; nxt_wa = a_addr; nxt_wd = a_data; m_last_b = 1'b0;
        end else if (exp_br) begin
            nxt_we = 1'b1; nxt_wa = b_addr; nxt_wd = b_data; m_last_b = 1'b1;
        end else begin
            nxt_we = 1'b0; nxt_wa = cur_wa; nxt_wd = cur_wd;
        end
    endfunction

    function automatic logic [31:0] exp_rd(input logic [2:0] ra, input logic [31:0] raw);
`ifdef RF_BYPASS_EN
        if (cur_we && (cur_wa == ra)) return cur_wd;
`endif
        return raw;
    endfunction

    task automatic advance();
        @(posedge clk); #1;
        cur_we = nxt_we; cur_wa = nxt_wa; cur_wd = nxt_wd;
    endtask

    task automatic test_reset();
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({rf_we, rf_wa, rf_wd, init_done, a_ready, b_ready} !== {1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_state: got we=%b wa=%0d wd=%h done=%b rdy=%b%b want all zero",
                     rf_we, rf_wa, rf_wd, init_done, a_ready, b_ready);
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            a_valid = (i < 7); b_valid = (i < 7);
            a_addr = 3'd1; b_addr = 3'd2; a_data = $urandom; b_data = $urandom;
            #1;
            n_checks++;
            if ({rf_we, rf_wa, rf_wd, init_done} !== {1'b1, 3'(i), 32'd0, (i == 7)}) begin
                n_errors++;
                $display("FAIL zero_fill i=%0d: got we=%b wa=%0d wd=%h done=%b want we=1 wa=%0d wd=0 done=%0d",
                         i, rf_we, rf_wa, rf_wd, init_done, i, (i == 7));
            end
            n_checks++;
            if ({a_ready, b_ready} !== 2'b00) begin
                n_errors++;
                $display("FAIL clear_ready i=%0d: got %b%b want 00", i, a_ready, b_ready);
            end
        end
        cur_we = 1'b1; cur_wa = 3'd7; cur_wd = 32'd0; m_last_b = 1'b1;
    endtask

    task automatic test_a_only();
        for (int k = 0; k < 3; k++) begin
            a_valid = (k == 0); a_addr = 3'd3; a_data = 32'haaaa_aaaa; b_valid = 1'b0;
            ra1 = 3'd0; ra2 = 3'd1; rf_rd1 = $urandom; rf_rd2 = $urandom;
            #1;
            predict();
            n_checks++;
            if ({a_ready, b_ready, rf_we, init_done} !== {exp_ar, exp_br, cur_we, 1'b1}) begin
                n_errors++;
                $display("FAIL a_only_ctl k=%0d: got %b want %b", k,
                         {a_ready, b_ready, rf_we, init_done}, {exp_ar, exp_br, cur_we, 1'b1});
            end
            n_checks++;
            if ({rf_wa, rf_wd} !== {cur_wa, cur_wd}) begin
                n_errors++;
                $display("FAIL a_only_wr k=%0d: got %0d/%h want %0d/%h", k, rf_wa, rf_wd, cur_wa, cur_wd);
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 7; k++) begin
            a_valid = (k >= 1 && k <= 4); a_addr = 3'd4; a_data = 32'h5555_5555;
            b_valid = (k <= 4);
            b_addr  = (k == 0) ? 3'd1 : 3'd5;
            b_data  = (k == 0) ? 32'hbbbb_0001 : 32'h1234_5678;
            ra1 = 3'(k); ra2 = 3'd5; rf_rd1 = $urandom; rf_rd2 = $urandom;
            #1;
            predict();
            n_checks++;
            if ({a_ready, b_ready, rf_we, init_done} !== {exp_ar, exp_br, cur_we, 1'b1}) begin
                n_errors++;
                $display("FAIL b2b_ctl k=%0d: got %b want %b", k,
                         {a_ready, b_ready, rf_we, init_done}, {exp_ar, exp_br, cur_we, 1'b1});
            end
            n_checks++;
            if ({rf_wa, rf_wd} !== {cur_wa, cur_wd}) begin
                n_errors++;
                $display("FAIL b2b_wr k=%0d: got %0d/%h want %0d/%h", k, rf_wa, rf_wd, cur_wa, cur_wd);
            end
            n_checks++;
            if ({rd1, rd2} !== {exp_rd(ra1, rf_rd1), exp_rd(ra2, rf_rd2)}) begin
                n_errors++;
                $display("FAIL b2b_rd k=%0d: got %h %h want %h %h", k, rd1, rd2,
                         exp_rd(ra1, rf_rd1), exp_rd(ra2, rf_rd2));
            end
            if (k >= 2 && k <= 5) begin
                n_checks++;
                if ({rf_we, rf_wa} !== {1'b1, ((k % 2) == 0) ? 3'd4 : 3'd5}) begin
                    n_errors++;
                    $display("FAIL b2b_seq k=%0d: got we=%b wa=%0d want we=1 wa=%0d", k, rf_we, rf_wa,
                             ((k % 2) == 0) ? 4 : 5);
                end
            end
            advance();
        end
    endtask

    task automatic test_same_addr();
        for (int k = 0; k < 5; k++) begin
            a_valid = (k <= 2);
            a_addr  = (k == 0) ? 3'd7 : 3'd6;
            a_data  = (k == 0) ? 32'h7777_7777 : 32'h8765_4321;
            b_valid = (k == 1); b_addr = 3'd6; b_data = 32'h1111_1111;
            ra1 = 3'd6; ra2 = 3'd7; rf_rd1 = $urandom; rf_rd2 = $urandom;
            #1;
            predict();
            n_checks++;
            if ({a_ready, b_ready, rf_we, init_done} !== {exp_ar, exp_br, cur_we, 1'b1}) begin
                n_errors++;
                $display("FAIL same_ctl k=%0d: got %b want %b", k,
                         {a_ready, b_ready, rf_we, init_done}, {exp_ar, exp_br, cur_we, 1'b1});
            end
            n_checks++;
            if ({rf_wa, rf_wd} !== {cur_wa, cur_wd}) begin
                n_errors++;
                $display("FAIL same_wr k=%0d: got %0d/%h want %0d/%h", k, rf_wa, rf_wd, cur_wa, cur_wd);
            end
            if (k == 2 || k == 3) begin
                n_checks++;
                if (rf_wd !== ((k == 2) ? 32'h1111_1111 : 32'h8765_4321)) begin
                    n_errors++;
                    $display("FAIL same_order k=%0d: got %h want %h", k, rf_wd,
                             (k == 2) ? 32'h1111_1111 : 32'h8765_4321);
                end
            end
            advance();
        end
        ra1 = 3'd6; rf_rd1 = rf_mem[6];
        #1;
        n_checks++;
        if (rd1 !== 32'h8765_4321) begin
            n_errors++;
            $display("FAIL same_readback: got %h want 87654321", rd1);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] raw;
        a_valid = 1'b1; a_addr = 3'd2; a_data = 32'h2222_2222; b_valid = 1'b0;
        ra1 = 3'd2; ra2 = 3'd2; rf_rd1 = 32'd0; rf_rd2 = 32'd0;
        #1;
        predict();
        advance();
        a_valid = 1'b0;
        #1;
        n_checks++;
        if ({rf_we, rf_wa, rd1, rd2} !== {1'b1, 3'd2, BYP_EXP, BYP_EXP}) begin
            n_errors++;
            $display("FAIL bypass_hit: got we=%b wa=%0d rd1=%h rd2=%h want we=1 wa=2 rd=%h",
                     rf_we, rf_wa, rd1, rd2, BYP_EXP);
        end
        predict();
        advance();
        raw = $urandom | 32'h1;
        rf_rd1 = raw;
        #1;
        n_checks++;
        if ({rf_we, rd1} !== {1'b0, raw}) begin
            n_errors++;
            $display("FAIL bypass_idle: got we=%b rd1=%h want we=0 rd1=%h", rf_we, rd1, raw);
        end
        predict();
        advance();
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            if (!a_valid || exp_ar) begin
                a_valid = ($urandom_range(0, 3) != 0); a_addr = 3'($urandom); a_data = $urandom;
            end else if ($urandom_range(0, 9) == 0) begin
                a_valid = 1'b0;
            end
            if (!b_valid || exp_br) begin
                b_valid = ($urandom_range(0, 3) != 0); b_addr = 3'($urandom); b_data = $urandom;
            end else if ($urandom_range(0, 9) == 0) begin
                b_valid = 1'b0;
            end
            ra1 = 3'($urandom); ra2 = 3'($urandom); rf_rd1 = $urandom; rf_rd2 = $urandom;
            #1;
            predict();
            n_checks++;
            if ({a_ready, b_ready, rf_we, init_done} !== {exp_ar, exp_br, cur_we, 1'b1}) begin
                n_errors++;
                $display("FAIL rand_ctl k=%0d: got %b want %b", k,
                         {a_ready, b_ready, rf_we, init_done}, {exp_ar, exp_br, cur_we, 1'b1});
            end
            n_checks++;
            if ({rf_wa, rf_wd} !== {cur_wa, cur_wd}) begin
                n_errors++;
                $display("FAIL rand_wr k=%0d: got %0d/%h want %0d/%h", k, rf_wa, rf_wd, cur_wa, cur_wd);
            end
            n_checks++;
            if ({rd1, rd2} !== {exp_rd(ra1, rf_rd1), exp_rd(ra2, rf_rd2)}) begin
                n_errors++;
                $display("FAIL rand_rd k=%0d: got %h %h want %h %h", k, rd1, rd2,
                         exp_rd(ra1, rf_rd1), exp_rd(ra2, rf_rd2));
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        a_valid = 1'b0; b_valid = 1'b1; b_addr = 3'd5; b_data = 32'hcafe_f00d; rst = 1'b1;
        #1;
        n_checks++;
        if ({a_ready, b_ready} !== 2'b01) begin
            n_errors++;
            $display("FAIL rstmid_accept: got %b%b want 01", a_ready, b_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({rf_we, init_done, a_ready, b_ready} !== 4'b0000) begin
            n_errors++;
            $display("FAIL rstmid_drop: got we=%b done=%b rdy=%b%b want 0000", rf_we, init_done, a_ready, b_ready);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            a_valid = (i == 7); a_addr = 3'd0; a_data = 32'h0a0a_0a0a;
            b_valid = (i == 7); b_addr = 3'd1; b_data = 32'hb0b0_b0b0;
            #1;
            n_checks++;
            if ({rf_we, rf_wa, rf_wd, init_done} !== {1'b1, 3'(i), 32'd0, (i == 7)}) begin
                n_errors++;
                $display("FAIL refill i=%0d: got we=%b wa=%0d wd=%h done=%b want we=1 wa=%0d wd=0 done=%0d",
                         i, rf_we, rf_wa, rf_wd, init_done, i, (i == 7));
            end
            if (i == 7) begin
                n_checks++;
                if ({a_ready, b_ready} !== 2'b10) begin
                    n_errors++;
                    $display("FAIL first_tie: got %b%b want 10", a_ready, b_ready);
                end
            end
        end
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        #1;
        n_checks++;
        if ({rf_we, rf_wa, rf_wd} !== {1'b1, 3'd0, 32'h0a0a_0a0a}) begin
            n_errors++;
            $display("FAIL reg0_write: got we=%b wa=%0d wd=%h want we=1 wa=0 wd=0a0a0a0a", rf_we, rf_wa, rf_wd);
        end
    endtask

    initial begin
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        a_addr = 3'd0; b_addr = 3'd0; a_data = 32'd0; b_data = 32'd0;
        ra1 = 3'd0; ra2 = 3'd0; rf_rd1 = 32'd0; rf_rd2 = 32'd0;
        exp_ar = 1'b0; exp_br = 1'b0; m_last_b = 1'b1;
        cur_we = 1'b0; cur_wa = 3'd0; cur_wd = 32'd0;
        nxt_we = 1'b0; nxt_wa = 3'd0; nxt_wd = 32'd0;
        test_reset();
        test_a_only();
        test_back_to_back();
        test_same_addr();
        test_bypass();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
